// File: rtl/immenc_pkg.sv
// Immediate encoder shared types: opcode classes, opcode match patterns and pipeline payloads.
package immenc_pkg;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_ERR} imm_class_t;

  // instr[6:2] patterns, written as value/mask pairs so signext can match the same way
  localparam logic [4:0] OP_I_VAL = 5'b00000;
  localparam logic [4:0] OP_I_MSK = 5'b11011;
  localparam logic [4:0] OP_S_VAL = 5'b01000;
  localparam logic [4:0] OP_B_VAL = 5'b11000;
  localparam logic [4:0] OP_U_VAL = 5'b00101;
  localparam logic [4:0] OP_U_MSK = 5'b10111;
  localparam logic [4:0] OP_J_VAL = 5'b11011;

  typedef struct packed {
    imm_class_t  cls;
    logic [31:0] imm;
    logic [24:0] base;
    logic        ok;
  } s1_t;

  typedef struct packed {
    logic [24:0] data;
    logic        err;
  } s2_t;

  function automatic imm_class_t op_class(input logic [4:0] op);
    imm_class_t c;
    c = IMM_ERR;
    if ((op & OP_I_MSK) == OP_I_VAL)      c = IMM_I;
    else if (op == OP_S_VAL)              c = IMM_S;
    else if (op == OP_B_VAL)              c = IMM_B;
    else if ((op & OP_U_MSK) == OP_U_VAL) c = IMM_U;
    else if (op == OP_J_VAL)              c = IMM_J;
    return c;
  endfunction

endpackage

// File: rtl/immenc_stage.sv
// One valid/ready register slice; accepts whenever empty or draining this cycle.
module immenc_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);

  assign in_rdy = !out_vld || out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (in_rdy) begin
      out_vld <= in_vld;
      if (in_vld) out_dat <= in_dat;
    end
  end

endmodule

// File: rtl/immenc.sv
// Immediate encoder: packs a 32-bit immediate into the I/S/B/U/J fields of instr[31:7].
// Two-stage valid/ready pipeline (classify+range check, then pack) with saturating statistics.
module immenc
  import immenc_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter bit STRICT = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [4:0]       Op,
  input  logic [31:0]      Imm,
  input  logic [24:0]      Base,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [24:0]      DataOut,
  output logic             ErrOut,
  output logic [CNT_W-1:0] EncCount,
  output logic [CNT_W-1:0] ErrCount
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  s1_t  s1_in, s1_out;
  s2_t  s2_in, s2_out;
  logic s1_vld, s2_rdy;

  // An immediate is representable when every bit above its sign position copies the sign.
  always_comb begin
    s1_in      = '0;
    s1_in.cls  = op_class(Op);
    s1_in.imm  = Imm;
    s1_in.base = Base;
    case (s1_in.cls)
      IMM_I, IMM_S: s1_in.ok = (&Imm[31:11]) || !(|Imm[31:11]);
      IMM_B:        s1_in.ok = !Imm[0] && ((&Imm[31:12]) || !(|Imm[31:12]));
      IMM_U:        s1_in.ok = !(|Imm[11:0]);
      IMM_J:        s1_in.ok = !Imm[0] && ((&Imm[31:20]) || !(|Imm[31:20]));
      default:      s1_in.ok = 1'b0;
    endcase
  end

  immenc_stage #(.W($bits(s1_t))) u_s1 (
    .clk     (clk),
    .rst_n   (reset_n),
    .in_vld  (InValid),
    .in_rdy  (InReady),
    .in_dat  (s1_in),
    .out_vld (s1_vld),
    .out_rdy (s2_rdy),
    .out_dat (s1_out)
  );

  always_comb begin
    s2_in      = '0;
    s2_in.data = s1_out.base;
    s2_in.err  = !s1_out.ok;
    case (s1_out.cls)
      IMM_I: s2_in.data[24:13] = s1_out.imm[11:0];
      IMM_S: begin
        s2_in.data[24:18] = s1_out.imm[11:5];
        s2_in.data[4:0]   = s1_out.imm[4:0];
      end
      IMM_B: begin
        s2_in.data[24]    = s1_out.imm[12];
        s2_in.data[23:18] = s1_out.imm[10:5];
        s2_in.data[4:1]   = s1_out.imm[4:1];
        s2_in.data[0]     = s1_out.imm[11];
      end
      IMM_U: s2_in.data[24:5] = s1_out.imm[31:12];
      IMM_J: begin
        s2_in.data[24]    = s1_out.imm[20];
        s2_in.data[23:14] = s1_out.imm[10:1];
        s2_in.data[13]    = s1_out.imm[11];
        s2_in.data[12:5]  = s1_out.imm[19:12];
      end
      default: s2_in.data = s1_out.base;
    endcase
    // Unsupported opcodes never get truncated fields, even in non-strict mode
    if (!s1_out.ok && (STRICT || s1_out.cls == IMM_ERR)) s2_in.data = s1_out.base;
  end

  immenc_stage #(.W($bits(s2_t))) u_s2 (
    .clk     (clk),
    .rst_n   (reset_n),
    .in_vld  (s1_vld),
    .in_rdy  (s2_rdy),
    .in_dat  (s2_in),
    .out_vld (OutValid),
    .out_rdy (OutReady),
    .out_dat (s2_out)
  );

  assign DataOut = s2_out.data;
  assign ErrOut  = s2_out.err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      EncCount <= '0;
      ErrCount <= '0;
    end else if (OutValid && OutReady) begin
      if (EncCount != CNT_MAX) EncCount <= EncCount + CNT_ONE;
      if (ErrOut && ErrCount != CNT_MAX) ErrCount <= ErrCount + CNT_ONE;
    end
  end

endmodule
